// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM states,
// phase encodings and the (prev, s) transition classifier.
package quad_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } move_t;

    // Phase values are {a, b}; A leads B when counting up.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    function automatic move_t classify(input logic [1:0] prev, input logic [1:0] s);
        logic [1:0] fwd;
        logic [1:0] bwd;
        case (prev)
            PH_00:   begin fwd = PH_10; bwd = PH_01; end
            PH_10:   begin fwd = PH_11; bwd = PH_00; end
            PH_11:   begin fwd = PH_01; bwd = PH_10; end
            default: begin fwd = PH_00; bwd = PH_11; end
        endcase
        if (s == prev) begin
            return NONE;
        end else if (s == fwd) begin
            return UP;
        end else if (s == bwd) begin
            return DOWN;
        end else begin
            return ILLEGAL;
        end
    endfunction

endpackage

// File: rtl/quad_sync.sv
// Single-bit metastability synchronizer: STAGES-deep flop chain, cleared
// to 0 by the asynchronous active-low reset.
module quad_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder with wrapping position count and step/error flags.
// Optional glitch filter compiled in with QUAD_GLITCH_FILTER_EN.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_sticky
);

    localparam int                INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    function automatic logic [CNT_W-1:0] wrap_step(input logic [CNT_W-1:0] c, input logic up);
        return up ? c + CNT_W'(1) : c - CNT_W'(1);
    endfunction

    logic              a_s;
    logic              b_s;
    logic [1:0]        ph_p0;
    logic [1:0]        acc;
    logic [1:0]        prev_q;
    logic [1:0]        prev_d;
    state_t            state_q;
    state_t            state_d;
    logic [INIT_W-1:0] init_cnt_q;
    logic [INIT_W-1:0] init_cnt_d;
    move_t             mv;
    logic [CNT_W-1:0]  count_d;
    logic              dir_d;
    logic              step_d;
    logic              err_d;
    logic              sticky_d;

    // ---- stage p0: phase synchronizers ----
    quad_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .d     (a_in),
        .q     (a_s)
    );

    quad_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .d     (b_in),
        .q     (b_s)
    );

    assign ph_p0 = {a_s, b_s};

    // ---- stage p1: accepted sample ----
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int                FILT_W   = $clog2(FILT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILT_CYCLES);

    logic [1:0]        ph_d;
    logic [FILT_W-1:0] run_len_q;
    logic [FILT_W-1:0] run_len;
    logic [1:0]        acc_p1;

    always_comb begin
        run_len = run_len_q;
        if (ph_p0 != ph_d) begin
            run_len = FILT_W'(1);
        end else if (run_len_q < FILT_MAX) begin
            run_len = run_len_q + FILT_W'(1);
        end
    end

    // During INIT the filter is bypassed so prev and the accepted sample agree on entry to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_d      <= '0;
            run_len_q <= '0;
            acc_p1    <= '0;
        end else begin
            ph_d      <= ph_p0;
            run_len_q <= run_len;
            if (state_q == INIT || run_len == FILT_MAX) begin
                acc_p1 <= ph_p0;
            end
        end
    end

    assign acc = acc_p1;
`else
    logic unused_filt;
    assign unused_filt = (FILT_CYCLES > 0);
    assign acc         = ph_p0;
`endif

    // ---- stage p2: decode, count and flags ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        count_d    = count;
        dir_d      = dir;
        step_d     = 1'b0;
        err_d      = 1'b0;
        sticky_d   = err_sticky;
        mv         = classify(prev_q, acc);

        case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = RUN;
                    prev_d  = acc;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                prev_d = acc;
                case (mv)
                    UP: begin
                        count_d = wrap_step(count, 1'b1);
                        dir_d   = 1'b1;
                        step_d  = 1'b1;
                    end
                    DOWN: begin
                        count_d = wrap_step(count, 1'b0);
                        dir_d   = 1'b0;
                        step_d  = 1'b1;
                    end
                    ILLEGAL: begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            default: state_d = INIT;
        endcase

        // Clear wins over a step, but an error in the same cycle still latches.
        if (clr) begin
            count_d = '0;
            if (!err_d) begin
                sticky_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= PH_00;
            count      <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            count      <= count_d;
            dir        <= dir_d;
            step       <= step_d;
            err        <= err_d;
            err_sticky <= sticky_d;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (default parameters);
// extra glitch-filter steps are built in when QUAD_GLITCH_FILTER_EN is defined.
module tb_quad_decoder;

    localparam int SYNC = 2;
    localparam int FILT = 3;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT  = SYNC + FILT + 1;
`else
    localparam int LAT  = SYNC + 1;
`endif
    localparam int HOLD = 8;

    logic       clk;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       clr;
    logic [3:0] count;
    logic       dir;
    logic       step;
    logic       err;
    logic       err_sticky;

    int compared   = 0;
    int mismatched = 0;
    int nstep      = 0;
    int nerr       = 0;
    int s0;
    int e0;
    logic [1:0] ph;

    quad_decoder #(
        .CNT_W       (4),
        .SYNC_STAGES (SYNC),
        .FILT_CYCLES (FILT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .clr        (clr),
        .count      (count),
        .dir        (dir),
        .step       (step),
        .err        (err),
        .err_sticky (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample just after the edge, and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("step_err_exclusive", {31'd0, step & err}, 32'd0);
        if (step === 1'b1) nstep++;
        if (err === 1'b1) nerr++;
    endtask

    task automatic drive(input logic [1:0] v);
        @(negedge clk);
        a_in = v[1];
        b_in = v[0];
        ph   = v;
    endtask

    function automatic logic [1:0] up_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] dn_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic move(input logic [1:0] v);
        drive(v);
        repeat (HOLD) tick();
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        a_in  = 1'b1;
        b_in  = 1'b1;
        clr   = 1'b0;
        ph    = 2'b11;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_dir", {31'd0, dir}, 32'd0);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_sticky", {31'd0, err_sticky}, 32'd0);

        // Power up at 11: no count, no flags, ends in RUN
        @(negedge clk);
        reset = 1'b1;
        s0 = nstep;
        e0 = nerr;
        repeat (10) tick();
        chk("init11_steps", 32'(nstep - s0), 32'd0);
        chk("init11_errs", 32'(nerr - e0), 32'd0);
        chk("init11_count", {28'd0, count}, 32'd0);
        chk("init11_state", 32'(dut.state_q), 32'(quad_pkg::RUN));

        // Re-initialise from 00
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) tick();

        // Full up cycle with latency check on the first edge
        s0 = nstep;
        drive(2'b10);
        repeat (LAT - 1) tick();
        chk("lat_before", {31'd0, step}, 32'd0);
        tick();
        chk("lat_step", {31'd0, step}, 32'd1);
        chk("lat_count", {28'd0, count}, 32'd1);
        repeat (HOLD - LAT) tick();
        move(2'b11);
        move(2'b01);
        move(2'b00);
        chk("upcyc_steps", 32'(nstep - s0), 32'd4);
        chk("upcyc_count", {28'd0, count}, 32'd4);
        chk("upcyc_dir", {31'd0, dir}, 32'd1);

        // Clear, then wrap up through 15 -> 0 and down 0 -> 15
        clr_pulse();
        chk("clr_count", {28'd0, count}, 32'd0);
        for (int i = 0; i < 15; i++) move(up_next(ph));
        chk("pre15_count", {28'd0, count}, 32'd15);
        move(up_next(ph));
        chk("wrap_up_count", {28'd0, count}, 32'd0);
        move(dn_next(ph));
        chk("wrap_dn_count", {28'd0, count}, 32'd15);
        chk("wrap_dn_dir", {31'd0, dir}, 32'd0);
        move(dn_next(ph));
        move(dn_next(ph));
        move(dn_next(ph));
        chk("dn3_count", {28'd0, count}, 32'd12);
        chk("dn3_phase", {30'd0, ph}, 32'd0);

        // Double-bit transition 00 -> 11
        s0 = nstep;
        e0 = nerr;
        move(2'b11);
        chk("illegal_errs", 32'(nerr - e0), 32'd1);
        chk("illegal_steps", 32'(nstep - s0), 32'd0);
        chk("illegal_sticky", {31'd0, err_sticky}, 32'd1);
        chk("illegal_count", {28'd0, count}, 32'd12);
        chk("illegal_dir", {31'd0, dir}, 32'd0);
        clr_pulse();
        chk("clr2_count", {28'd0, count}, 32'd0);
        chk("clr2_sticky", {31'd0, err_sticky}, 32'd0);

        // Clear coinciding with a down step
        move(2'b01);
        chk("pre_clrstep_count", {28'd0, count}, 32'd1);
        chk("pre_clrstep_dir", {31'd0, dir}, 32'd1);
        drive(2'b11);
        repeat (LAT - 1) tick();
        @(negedge clk);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrstep_step", {31'd0, step}, 32'd1);
        chk("clrstep_count", {28'd0, count}, 32'd0);
        chk("clrstep_dir", {31'd0, dir}, 32'd0);
        repeat (HOLD) tick();

        // Clear coinciding with an error: sticky still sets
        drive(2'b00);
        repeat (LAT - 1) tick();
        @(negedge clk);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrerr_err", {31'd0, err}, 32'd1);
        chk("clrerr_sticky", {31'd0, err_sticky}, 32'd1);
        chk("clrerr_count", {28'd0, count}, 32'd0);
        repeat (HOLD) tick();
        chk("clrerr_sticky_hold", {31'd0, err_sticky}, 32'd1);

        // Async reset mid-sequence
        move(2'b10);
        chk("pre_rst_count", {28'd0, count}, 32'd1);
        chk("pre_rst_dir", {31'd0, dir}, 32'd1);
        drive(2'b11);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_count", {28'd0, count}, 32'd0);
        chk("midrst_dir", {31'd0, dir}, 32'd0);
        chk("midrst_step", {31'd0, step}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_sticky", {31'd0, err_sticky}, 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(quad_pkg::INIT));
        @(negedge clk);
        reset = 1'b1;
        s0 = nstep;
        e0 = nerr;
        repeat (12) tick();
        chk("reinit_steps", 32'(nstep - s0), 32'd0);
        chk("reinit_errs", 32'(nerr - e0), 32'd0);
        chk("reinit_count", {28'd0, count}, 32'd0);
        chk("reinit_state", 32'(dut.state_q), 32'(quad_pkg::RUN));

`ifdef QUAD_GLITCH_FILTER_EN
        // Two-cycle glitch on A is discarded; a held edge counts once
        s0 = nstep;
        e0 = nerr;
        @(negedge clk);
        a_in = 1'b0;
        tick();
        tick();
        @(negedge clk);
        a_in = 1'b1;
        repeat (12) tick();
        chk("glitch_steps", 32'(nstep - s0), 32'd0);
        chk("glitch_errs", 32'(nerr - e0), 32'd0);
        drive(2'b01);
        repeat (LAT - 1) tick();
        chk("filt_lat_before", {31'd0, step}, 32'd0);
        tick();
        chk("filt_lat_step", {31'd0, step}, 32'd1);
        repeat (HOLD) tick();
        chk("filt_steps", 32'(nstep - s0), 32'd1);
        chk("filt_count", {28'd0, count}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Incremental (quadrature) encoder reader: samples two phase inputs A/B, decodes each legal Gray-code step as +1 or -1, and keeps a wrapping position count with direction, step and error flags. It is the receiving end of the up/down counting interface. An external encoder or up/down stimulus drives the phases, and this block recovers the count. It feeds the position/status logic of the design.

Parameters:
CNT_W, 4, width of position counter (modulo 2^CNT_W)
SYNC_STAGES, 2, flops in input synchronizer per phase (min 2)
FILT_CYCLES, 3, stability cycles required when glitch filter compiled in (min 1)

Ports:
clk  input  1  single system clock, all state on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
a_in  input  1  phase A, asynchronous to clk
b_in  input  1  phase B, asynchronous to clk
clr  input  1  synchronous count clear, active-high
count  output  CNT_W  current position
dir  output  1  direction of last legal step (1 = up, 0 = down)
step  output  1  one-cycle pulse per legal step
err  output  1  one-cycle pulse on illegal (double-bit) transition
err_sticky  output  1  set by err, cleared by clr or reset

Behaviour:
- Reset (reset=0, async): count=0, dir=0, step=0, err=0, err_sticky=0, synchronizer flops=0, prev=00, FSM=INIT, init counter=0.
- Phase value s={a,b} is taken after SYNC_STAGES flops.
- Up sequence: 00->10->11->01->00 (A leads). Down sequence is the reverse. x4 decoding: each legal edge is one count.
- FSM INIT: waits SYNC_STAGES+1 cycles after reset release, then loads prev=s without counting or flagging and goes to RUN. Any power-up phase value is accepted this way.
- FSM RUN, evaluated each cycle on the accepted sample s versus prev:
  - s==prev: no action; step=0, err=0.
  - legal up: count<=count+1, dir<=1, step=1.
  - legal down: count<=count-1, dir<=0, step=1.
  - both bits changed: err=1, err_sticky<=1, count and dir unchanged, step=0.
  - In all cases prev<=s.
- Wrap-around: modulo 2^CNT_W with no saturation. With CNT_W=4, 15 +1 gives 0 and 0 -1 gives 15.
- Latency: a phase edge at the a_in/b_in pins appears on count/step SYNC_STAGES+1 rising edges later. step/err are registered.
- clr in the same cycle as a step: count<=0, which takes priority over the increment or decrement. dir and step still reflect the transition. err_sticky<=0 unless err is asserted in that same cycle, in which case it is set.
- clr in INIT: count stays 0, and the FSM continues INIT normally.
- Reset mid-operation: immediate return to the reset values and INIT, regardless of state.
- step and err are never both 1.

Optional Feature:
QUAD_GLITCH_FILTER_EN
- Defined: a synchronized value s differing from prev becomes the accepted sample only after it has been stable for FILT_CYCLES consecutive cycles. Shorter pulses are discarded with no step and no err. Latency becomes SYNC_STAGES+FILT_CYCLES+1. The filter counter resets whenever s changes, and on reset.
- Undefined: no filter; the synchronized s is accepted every cycle.

Decomposition:
- Package quad_pkg:
  - FSM state enum {INIT, RUN}.
  - Phase encodings PH_00/PH_10/PH_11/PH_01.
  - Function classifying (prev, s) as NONE/UP/DOWN/ILLEGAL.
- Sub-module quad_sync: SYNC_STAGES-deep flop chain for one phase, async active-low reset to 0. Instantiated twice.

Test Plan:
- Release reset with a=b=1 held, then wait 10 cycles -> count=0, step never pulses, err never pulses, FSM in RUN.
- After INIT from 00, drive 00->10->11->01->00, holding each value 8 cycles -> 4 step pulses, dir=1, count=4. First step arrives 3 cycles after the a_in edge (SYNC_STAGES=2).
- Preload count=15 via 15 up-steps, then 1 up-step -> count=0. Then 1 down-step -> count=15, dir=0.
- From 00, drive a,b to 11 simultaneously -> err=1 for exactly one cycle, err_sticky=1, count unchanged. Then clr=1 for one cycle -> count=0, err_sticky=0.
- Assert clr in the same cycle step would fire -> count=0, step=1, dir updated. Drop reset mid-sequence -> all outputs 0 asynchronously and INIT re-entered.
- With QUAD_GLITCH_FILTER_EN and FILT_CYCLES=3: 2-cycle pulse on a_in -> no step, no err. 3-cycle stable edge -> exactly one step, SYNC_STAGES+FILT_CYCLES+1 cycles after the edge.
